// File: rtl/zmod_rx_align.sv
// Receive word aligner: finds a sync byte in lane 3, bit-slips all four lanes
// by the same amount, delivers the 24-bit payload once locked, and counts
// delivered words and payload sequence errors.
//
// Handshake: din is consumed on every clk edge where din_valid is high (there
// is no backpressure); dout is meaningful only on cycles where dout_valid is
// high, and each such cycle delivers exactly one word.
module zmod_rx_align #(
    parameter int unsigned LOCK_COUNT   = 16,
    parameter int unsigned UNLOCK_COUNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic        din_valid,
    input  logic        clear,
    output logic [23:0] dout,
    output logic        dout_valid,
    output logic        locked,
    output logic [2:0]  shift,
    output logic [31:0] err_count,
    output logic [31:0] word_count,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(UNLOCK_COUNT - 1);

    state_t        state_q;
    logic [2:0]    shift_q;
    logic [31:0]   prev_q;
    logic [GW-1:0] good_q;
    logic [MW-1:0] miss_q;
    logic          locked_q;

    logic [23:0]   s1_data_q;
    logic          s1_valid_q;
    logic [23:0]   dout_q;
    logic          dout_valid_q;

    logic [23:0]   exp_q;
    logic          have_exp_q;
    logic [31:0]   err_q;
    logic [31:0]   wc_q;

    logic [31:0]   aligned;
    logic          good_sync;
    logic          hunt_hit;
    logic [2:0]    hunt_idx;

    // Each lane is slipped by the same amount using its previous valid byte.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [15:0] pair;
        assign pair = {prev_q[8*k +: 8], din[8*k +: 8]} >> shift_q;
        assign aligned[8*k +: 8] = pair[7:0];
    end

    assign good_sync = (aligned[31:24] == 8'h01);

    // Hunt candidate: raw sync lane must be exactly one-hot; its bit is the slip.
    always_comb begin
        hunt_hit = 1'b0;
        hunt_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (din[31:24] == (8'd1 << i)) begin
                hunt_hit = 1'b1;
                hunt_idx = 3'(i);
            end
        end
    end

    // Alignment FSM: hunt for a candidate, verify a run of good syncs, hold lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            shift_q  <= 3'd0;
            prev_q   <= 32'd0;
            good_q   <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
        end else if (din_valid) begin
            prev_q <= din;
            case (state_q)
                HUNT: begin
                    if (hunt_hit) begin
                        shift_q <= hunt_idx;
                        good_q  <= '0;
                        state_q <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (!good_sync) begin
                        state_q <= HUNT;
                    end else if (good_q == GOOD_LAST) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        miss_q   <= '0;
                    end else begin
                        good_q <= good_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (good_sync) begin
                        miss_q <= '0;
                    end else if (miss_q == MISS_LAST) begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end else begin
                        miss_q <= miss_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= HUNT;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage delivery pipeline; both stages are gated by the current lock
    // state so words in flight are dropped as soon as lock is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q    <= 24'd0;
            s1_valid_q   <= 1'b0;
            dout_q       <= 24'd0;
            dout_valid_q <= 1'b0;
        end else begin
            s1_valid_q   <= din_valid && (state_q == LOCKED);
            dout_valid_q <= s1_valid_q && (state_q == LOCKED);
            if (din_valid) begin
                s1_data_q <= aligned[23:0];
            end
            if (s1_valid_q) begin
                dout_q <= s1_data_q;
            end
        end
    end

    // Payload sequence checker and saturating counters; clear has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q      <= 24'd0;
            have_exp_q <= 1'b0;
            err_q      <= 32'd0;
            wc_q       <= 32'd0;
        end else begin
            if (dout_valid_q) begin
                if (wc_q != 32'hFFFF_FFFF) begin
                    wc_q <= wc_q + 32'd1;
                end
                if (have_exp_q && (dout_q != exp_q) && (err_q != 32'hFFFF_FFFF)) begin
                    err_q <= err_q + 32'd1;
                end
                exp_q      <= dout_q + 24'd1;
                have_exp_q <= 1'b1;
            end
            // Outside LOCKED the next delivered word must reseed the check.
            if (state_q != LOCKED) begin
                have_exp_q <= 1'b0;
            end
            if (clear) begin
                err_q <= 32'd0;
                wc_q  <= 32'd0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign locked     = locked_q;
    assign shift      = shift_q;
    assign err_count  = err_q;
    assign word_count = wc_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_zmod_rx_align.sv
// Directed bench for zmod_rx_align with a word-level reference model.
module tb_zmod_rx_align;
    localparam int LOCK_N   = 16;
    localparam int UNLOCK_N = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] din = 32'd0;
    logic        din_valid = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] dout;
    logic        dout_valid;
    logic        locked;
    logic [2:0]  shift;
    logic [31:0] err_count;
    logic [31:0] word_count;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    zmod_rx_align #(
        .LOCK_COUNT  (LOCK_N),
        .UNLOCK_COUNT(UNLOCK_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .dout      (dout),
        .dout_valid(dout_valid),
        .locked    (locked),
        .shift     (shift),
        .err_count (err_count),
        .word_count(word_count),
        .state_dbg (state_dbg)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Lane k aligned byte = bits [s+7:s] of {prev_k, cur_k}.
    function automatic logic [31:0] align_word(input logic [31:0] prev, input logic [31:0] cur, input int s);
        logic [15:0] p;
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            p = {prev[8*k +: 8], cur[8*k +: 8]};
            r[8*k +: 8] = p[s +: 8];
        end
        return r;
    endfunction

    // Raw word as the deserializer would present an ideal stream slipped by s.
    function automatic logic [31:0] mk_raw(input logic [31:0] cur, input logic [31:0] nxt, input int s);
        logic [15:0] p;
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            p = {cur[8*k +: 8], nxt[8*k +: 8]};
            r[8*k +: 8] = p[(8 - s) +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    typedef struct {
        int          due;
        logic [23:0] d;
    } pend_t;

    pend_t       pq[$];
    int          m_state, m_shift, m_good, m_miss, e_cnt;
    logic [31:0] m_prev;
    bit          m_dv, m_seeded;
    logic [23:0] m_dout, m_exp;
    logic [31:0] m_err, m_wc;

    // Model: words accepted while locked are due one edge later unless lock
    // is lost first; counters act on what was visible before the edge.
    always @(posedge clk) begin : model
        logic [31:0] al;
        logic [7:0]  rs;
        pend_t       p;
        e_cnt++;
        if (rst) begin
            m_state = 0; m_shift = 0; m_good = 0; m_miss = 0;
            m_prev = 32'd0; m_dv = 1'b0; m_dout = 24'd0; m_exp = 24'd0;
            m_seeded = 1'b0; m_err = 32'd0; m_wc = 32'd0;
            pq.delete();
        end else begin
            if (m_dv) begin
                m_wc = sat_inc(m_wc);
                if (m_seeded && (m_dout != m_exp)) m_err = sat_inc(m_err);
                m_exp = m_dout + 24'd1;
                m_seeded = 1'b1;
            end
            if (clear) begin
                m_err = 32'd0;
                m_wc  = 32'd0;
            end
            if (din_valid) begin
                al = align_word(m_prev, din, m_shift);
                rs = din[31:24];
                if (m_state == 2) begin
                    p.due = e_cnt + 1;
                    p.d   = al[23:0];
                    pq.push_back(p);
                end
                if (m_state == 0) begin
                    if (rs != 8'd0 && (rs & (rs - 8'd1)) == 8'd0) begin
                        m_shift = $clog2(rs);
                        m_good  = 0;
                        m_state = 1;
                    end
                end else if (m_state == 1) begin
                    if (al[31:24] == 8'h01) begin
                        m_good++;
                        if (m_good == LOCK_N) begin
                            m_state  = 2;
                            m_miss   = 0;
                            m_seeded = 1'b0;
                        end
                    end else begin
                        m_state = 0;
                    end
                end else begin
                    if (al[31:24] == 8'h01) m_miss = 0;
                    else m_miss++;
                    if (m_miss == UNLOCK_N) begin
                        m_state = 0;
                        while (pq.size() > 0 && pq[pq.size()-1].due > e_cnt) void'(pq.pop_back());
                    end
                end
                m_prev = din;
            end
            m_dv = 1'b0;
            if (pq.size() > 0 && pq[0].due == e_cnt) begin
                m_dv   = 1'b1;
                m_dout = pq[0].d;
                void'(pq.pop_front());
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("locked", locked, (m_state == 2));
            check("state", state_dbg, m_state[1:0]);
            check("shift", shift, m_shift[2:0]);
            check("dout_valid", dout_valid, m_dv);
            if (m_dv) check("dout", dout, m_dout);
            check("err_count", err_count, m_err);
            check("word_count", word_count, m_wc);
        end
    end

    // ---------------- driver tasks ----------------
    logic [31:0] ideal_q[$];

    task automatic drive(input logic [31:0] w, input bit v, input bit clr);
        din       = w;
        din_valid = v;
        clear     = clr;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(32'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic send_range(input int lo, input int hi, input int s, input bit randv);
        logic [31:0] nxt;
        for (int i = lo; i < hi; i++) begin
            nxt = (i + 1 < ideal_q.size()) ? ideal_q[i+1] : ideal_q[i];
            if (randv) begin
                while ($urandom_range(0, 1) == 0) idle(1);
            end
            drive(mk_raw(ideal_q[i], nxt, s), 1'b1, 1'b0);
        end
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        do_reset();
        check("rst_locked", locked, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        check("rst_shift", shift, 3'd0);
        check("rst_dout", dout, 24'd0);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_err", err_count, 32'd0);
        check("rst_wc", word_count, 32'd0);

        // Aligned stream, payload counting from 0.
        ideal_q.delete();
        for (int i = 0; i < 40; i++) ideal_q.push_back({8'h01, 24'(i)});
        send_range(0, 16, 0, 1'b0);
        check("t1_unlocked_16", locked, 1'b0);
        send_range(16, 17, 0, 1'b0);
        check("t1_locked_17", locked, 1'b1);
        check("t1_shift", shift, 3'd0);
        send_range(17, 40, 0, 1'b0);
        idle(3);
        check("t1_err", err_count, 32'd0);
        check("t1_wc", word_count, 32'd23);
        check("t1_last_dout", dout, 24'h000027);

        // Stream slipped so the sync sits at bit 5.
        do_reset();
        ideal_q.delete();
        for (int i = 0; i < 30; i++) ideal_q.push_back({8'h01, 24'h000100 + 24'(i)});
        send_range(0, 30, 5, 1'b0);
        idle(3);
        check("t2_shift", shift, 3'd5);
        check("t2_locked", locked, 1'b1);
        check("t2_err", err_count, 32'd0);
        check("t2_wc", word_count, 32'd13);
        check("t2_last_dout", dout, 24'h00011D);

        // Wrap through FFFFFF -> 000000, then 000010 replaced by 000055.
        do_reset();
        ideal_q.delete();
        for (int i = 0; i < 55; i++) begin
            if (i < 48) ideal_q.push_back({8'h01, 24'hFFFFE0 + 24'(i)});
            else        ideal_q.push_back({8'h01, 24'h000055 + 24'(i - 48)});
        end
        send_range(0, 55, 0, 1'b0);
        idle(3);
        check("t3_err_one", err_count, 32'd1);
        check("t3_wc", word_count, 32'd38);
        check("t3_last_dout", dout, 24'h00005B);
        // An out-of-sequence word whose error lands together with clear.
        drive({8'h01, 24'h000999}, 1'b1, 1'b0);
        drive(32'd0, 1'b0, 1'b0);
        drive(32'd0, 1'b0, 1'b1);
        check("t3_clear_err", err_count, 32'd0);
        check("t3_clear_wc", word_count, 32'd0);

        // Miss tolerance: 3 bad then good holds lock; 4 bad drops it.
        do_reset();
        ideal_q.delete();
        for (int i = 0; i < 30; i++) begin
            if ((i >= 20 && i <= 22) || (i >= 24 && i <= 27)) ideal_q.push_back({8'h00, 24'(i)});
            else ideal_q.push_back({8'h01, 24'(i)});
        end
        send_range(0, 24, 0, 1'b0);
        check("t4_hold", locked, 1'b1);
        send_range(24, 28, 0, 1'b0);
        check("t4_unlocked", locked, 1'b0);
        check("t4_hunt", state_dbg, 2'd0);
        check("t4_last_inflight", dout_valid, 1'b1);
        idle(1);
        check("t4_dv_dropped", dout_valid, 1'b0);
        idle(2);
        check("t4_err", err_count, 32'd0);
        check("t4_wc", word_count, 32'd10);

        // Random din_valid gaps with a 3-bit slip, then reset mid-lock.
        do_reset();
        ideal_q.delete();
        for (int i = 0; i < 41; i++) ideal_q.push_back({8'h01, 24'h007000 + 24'(i)});
        send_range(0, 40, 3, 1'b1);
        idle(3);
        check("t5_locked", locked, 1'b1);
        check("t5_shift", shift, 3'd3);
        check("t5_err", err_count, 32'd0);
        check("t5_wc", word_count, 32'd23);
        send_range(40, 41, 3, 1'b0);
        do_reset();
        check("t5_rst_dv", dout_valid, 1'b0);
        check("t5_rst_locked", locked, 1'b0);
        check("t5_rst_wc", word_count, 32'd0);
        idle(3);
        check("t5_rst_quiet", dout_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zmod_rx_align.md
ZMOD_RX_ALIGN -- requirements
Module: zmod_rx_align

Interface
REQ-001 Parameter LOCK_COUNT, default 16: consecutive good sync bytes needed to declare lock.
REQ-002 Parameter UNLOCK_COUNT, default 4: consecutive bad sync bytes needed to drop lock.
REQ-003 clk  in  1  single clock for all logic: the 100 MHz fabric clock, same domain as the rx CDC fifo read side.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 din  in  32  raw deserialized word from the fifo; [31:24] sync lane; [23:16], [15:8], [7:0] data lanes 2..0.
REQ-006 din_valid  in  1  din qualifier; words with din_valid low are ignored entirely.
REQ-007 clear  in  1  one-cycle pulse that zeroes err_count and word_count.
REQ-008 dout  out  24  aligned payload, lanes 2..0 concatenated.
REQ-009 dout_valid  out  1  dout qualifier, high only while locked.
REQ-010 locked  out  1  high in state LOCKED.
REQ-011 shift  out  3  current bit-slip value applied to all four lanes.
REQ-012 err_count  out  32  payload sequence errors seen while locked, saturating.
REQ-013 word_count  out  32  words delivered with dout_valid, saturating.

Function
REQ-014 Per lane k, the block shall hold prev_k, the lane-k byte of the last valid word, updated only on din_valid.
REQ-015 aligned_k shall equal bits [shift+7:shift] of {prev_k, cur_k}, i.e. ({prev_k, cur_k} >> shift)[7:0].
REQ-016 The aligned sync byte is aligned_3; a good sync is aligned_3 == 8'h01.
REQ-017 FSM states are HUNT, VERIFY and LOCKED; the reset state is HUNT.
REQ-018 HUNT, valid word with din[31:24] one-hot at bit n: load shift = n and go to VERIFY with good-count = 0.
REQ-019 HUNT, valid word that is not one-hot: stay in HUNT and keep shift unchanged.
REQ-020 VERIFY: each valid good sync increments good-count; when it reaches LOCK_COUNT, go to LOCKED.
REQ-021 VERIFY: any valid bad sync returns to HUNT in the same cycle.
REQ-022 LOCKED: a valid bad sync increments miss-count; a good sync zeroes it; reaching UNLOCK_COUNT returns to HUNT.
REQ-023 Pipeline stage 1 shall register the aligned bytes and a state-qualified valid; stage 2 shall register dout and dout_valid.
REQ-024 dout_valid shall assert exactly 2 clk after a valid din accepted while locked was high.
REQ-025 Payload check: the first dout_valid word after each entry to LOCKED seeds the expected value and is not checked.
REQ-026 Each later dout_valid word shall be compared with the expected value (previous payload + 1, mod 2^24, so 24'hFFFFFF -> 24'h000000 is legal); a mismatch increments err_count and reseeds the expected value from the received word.
REQ-027 A word with a bad sync in LOCKED (before unlock) shall still be delivered and checked.
REQ-028 Both counters shall saturate at 32'hFFFFFFFF.
REQ-029 If clear and an increment occur in the same cycle, the counter shall read 0 on the next cycle (clear wins).
REQ-030 Leaving LOCKED shall drop dout_valid for in-flight words on the following cycle; no partially aligned word shall ever be marked valid.

Reset
REQ-031 On rst high at a clk edge: state = HUNT, shift = 0, prev_k = 0, the good-count and miss-count internal counters = 0, dout = 0, dout_valid = 0, locked = 0, err_count = 0, word_count = 0.
REQ-032 Reset asserted mid-lock takes effect on the next edge and discards all pipeline contents.
REQ-033 The first valid word after reset is treated as a HUNT candidate.

Verification
REQ-034 Aligned stream (sync 8'h01, payload counting from 0): locked rises after 17 valid words, shift = 0, dout increments by 1, err_count = 0.
REQ-035 Stream bit-rotated so the sync sits at bit 5: shift = 5, lock achieved, dout increments cleanly, err_count = 0.
REQ-036 Locked, then payload 24'h000010 replaced by 24'h000055: err_count = 1, and the following word 24'h000056 produces no error.
REQ-037 Locked, then 3 bad syncs followed by a good one: lock held. Then 4 consecutive bad syncs: locked = 0, state HUNT, dout_valid low 1 cycle later.
REQ-038 Payload wrap 24'hFFFFFE -> FFFFFF -> 000000: no error. clear asserted together with an error: err_count = 0.
REQ-039 din_valid toggled 50% randomly on a clean stream: lock is still reached after 17 valid words, alignment is unaffected, word_count equals the number of dout_valid cycles.
